// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Imported by pipe_hazard_ctrl and hazard_detect.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 4;
    localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic freeze_front;
        logic flush_if_id;
        logic flush_id_ex;
        logic freeze_back;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // A source operand only hazards when the instruction actually reads it.
    function automatic logic idx_match(input logic used,
                                       input logic [REG_IDX_W-1:0] src,
                                       input logic [REG_IDX_W-1:0] dest);
        return used & (src == dest);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW hazard detection between the ID instruction and EXE/MEM destinations.
// With PIPE_HAZARD_FWD_EN defined, forwarding covers ALU results, so only load-use stalls.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] src1,
    input  logic                 src1_used,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 two_src,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    output logic                 raw
);

    logic exe_hit;

    assign exe_hit = idx_match(src1_used, src1, exe_dest) |
                     idx_match(two_src, src2, exe_dest);

`ifdef PIPE_HAZARD_FWD_EN
    logic unused_mem_fields;

    assign unused_mem_fields = ^{mem_dest, mem_wb_en};
    assign raw = exe_mem_r_en & exe_wb_en & exe_hit;
`else
    logic mem_hit;
    logic unused_load_flag;

    assign unused_load_flag = exe_mem_r_en;
    assign mem_hit = idx_match(src1_used, src1, mem_dest) |
                     idx_match(two_src, src2, mem_dest);
    assign raw = (exe_wb_en & exe_hit) | (mem_wb_en & mem_hit);
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline, with memory-wait watchdog and stall counter.
// Optional macro PIPE_HAZARD_FWD_EN selects the load-use-only hazard check in hazard_detect.
//
// state | meaning
// RUN   | no outstanding data-memory wait
// WAIT  | MEM stage stalled on data memory; wait_cnt counts cycles up to MAX_WAIT
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT    = 15,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_IDX_W-1:0]   src1,
    input  logic                   src1_used,
    input  logic [REG_IDX_W-1:0]   src2,
    input  logic                   two_src,
    input  logic [REG_IDX_W-1:0]   exe_dest,
    input  logic                   exe_wb_en,
    input  logic                   exe_mem_r_en,
    input  logic [REG_IDX_W-1:0]   mem_dest,
    input  logic                   mem_wb_en,
    input  logic                   mem_req,
    input  logic                   sram_ready,
    input  logic                   branch_taken,
    output logic                   freeze_front,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic                   freeze_back,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t                 state;
    state_t                 state_nxt;
    logic [WAIT_W-1:0]      wait_cnt;
    logic [WAIT_W-1:0]      wait_cnt_nxt;
    logic                   mem_err_nxt;
    logic [STALL_CNT_W-1:0] stall_cnt_nxt;
    logic                   mem_busy;
    logic                   raw;
    ctrl_t                  ctrl;

    assign mem_busy = mem_req & ~sram_ready;

    hazard_detect u_hazard_detect (
        .src1         (src1),
        .src1_used    (src1_used),
        .src2         (src2),
        .two_src      (two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .raw          (raw)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_err   <= mem_err_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            WAIT: begin
                if (!mem_busy) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt != WAIT_LIMIT) begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase

        // Sticky: only the cycle that lands on the limit needs to set it.
        mem_err_nxt = mem_err | (wait_cnt_nxt == WAIT_LIMIT);

        stall_cnt_nxt = stall_cnt;
        if (ctrl.freeze_front && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_nxt = stall_cnt + STALL_CNT_W'(1);
        end
    end

    // A pending memory access outranks a branch so the redirect is not lost mid-wait.
    always_comb begin
        ctrl = CTRL_IDLE;
        if (reset) begin
            ctrl = CTRL_IDLE;
        end else if (mem_busy) begin
            ctrl.freeze_front = 1'b1;
            ctrl.freeze_back  = 1'b1;
        end else if (branch_taken) begin
            ctrl.flush_if_id  = 1'b1;
            ctrl.flush_id_ex  = 1'b1;
        end else if (raw) begin
            ctrl.freeze_front = 1'b1;
            ctrl.flush_id_ex  = 1'b1;
        end
    end

    assign freeze_front = ctrl.freeze_front;
    assign flush_if_id  = ctrl.flush_if_id;
    assign flush_id_ex  = ctrl.flush_id_ex;
    assign freeze_back  = ctrl.freeze_back;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MAX_WAIT=15, STALL_CNT_W=16).
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src1, src2, exe_dest, mem_dest;
    logic        src1_used, two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic        mem_req, sram_ready, branch_taken;
    logic        freeze_front, flush_if_id, flush_id_ex, freeze_back, mem_err;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    int exp_stall = 0;

    pipe_hazard_ctrl #(.MAX_WAIT(15), .STALL_CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .src1         (src1),
        .src1_used    (src1_used),
        .src2         (src2),
        .two_src      (two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .mem_req      (mem_req),
        .sram_ready   (sram_ready),
        .branch_taken (branch_taken),
        .freeze_front (freeze_front),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .freeze_back  (freeze_back),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        src1 = 4'd0; src1_used = 1'b0; src2 = 4'd0; two_src = 1'b0;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0;
        mem_req = 1'b0; sram_ready = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic check_ctrl(input string tag, input logic [3:0] exp);
        check({tag, ".ctrl"}, {28'd0, freeze_front, flush_if_id, flush_id_ex, freeze_back}, {28'd0, exp});
    endtask

    // Called just after a rising edge: check controls mid-cycle, advance one edge, check the counter.
    task automatic step(input string tag, input logic [3:0] exp);
        #1 check_ctrl(tag, exp);
        @(posedge clk);
        if (exp[3]) exp_stall++;
        #1 check({tag, ".stall"}, {16'd0, stall_cnt}, exp_stall);
    endtask

    // exp encoding: {freeze_front, flush_if_id, flush_id_ex, freeze_back}
    initial begin
        reset = 1'b1;
        idle_inputs();
        #3;
        check_ctrl("rst_idle", 4'b0000);
        check("rst_stall", {16'd0, stall_cnt}, 0);
        check("rst_err", {31'd0, mem_err}, 0);
        check("rst_state", {31'd0, dut.state}, {31'd0, RUN});
        src1 = 4'd3; src1_used = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
        mem_req = 1'b1;
        #1 check_ctrl("rst_forced", 4'b0000);
        @(posedge clk);
        #1 check("rst_stall_hold", {16'd0, stall_cnt}, 0);
        reset = 1'b0;
        idle_inputs();
        step("idle", 4'b0000);

        // EXE RAW on src1: one bubble per cycle, stall_cnt +1 per cycle
        src1 = 4'd3; src1_used = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
        step("raw_exe_c1", FWD ? 4'b0000 : 4'b1010);
        step("raw_exe_c2", FWD ? 4'b0000 : 4'b1010);
        exe_mem_r_en = 1'b1;
        step("load_use", 4'b1010);
        idle_inputs();

        // src2 against MEM stage, register 15 treated as ordinary index
        src2 = 4'd15; two_src = 1'b1; mem_dest = 4'd15; mem_wb_en = 1'b1;
        step("raw_mem_pc", FWD ? 4'b0000 : 4'b1010);
        two_src = 1'b0;
        step("src2_unused", 4'b0000);
        idle_inputs();
        src1 = 4'd3; src1_used = 1'b1; exe_dest = 4'd4; exe_wb_en = 1'b1;
        step("idx_mismatch", 4'b0000);
        src1 = 4'd4; exe_wb_en = 1'b0;
        step("no_wb", 4'b0000);
        idle_inputs();

        // branch overrides a concurrent RAW
        src1 = 4'd5; src1_used = 1'b1; exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
        branch_taken = 1'b1;
        step("branch_raw", 4'b0110);
        idle_inputs();

        // 4-cycle memory wait, branch pending in the middle of it
        mem_req = 1'b1; sram_ready = 1'b0;
        step("mw_c1", 4'b1001);
        check("mw_state", {31'd0, dut.state}, {31'd0, WAIT});
        step("mw_c2", 4'b1001);
        branch_taken = 1'b1;
        step("mw_c3_br", 4'b1001);
        branch_taken = 1'b0;
        step("mw_c4", 4'b1001);
        sram_ready = 1'b1;
        step("mw_release", 4'b0000);
        check("mw_state_run", {31'd0, dut.state}, {31'd0, RUN});
        check("mw_err", {31'd0, mem_err}, 0);
        idle_inputs();

        // watchdog: 20 busy cycles, error appears after the 15th
        mem_req = 1'b1; sram_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step("wd_busy", 4'b1001);
            check($sformatf("wd_err_c%0d", i), {31'd0, mem_err}, (i >= 15) ? 1 : 0);
        end
        sram_ready = 1'b1;
        step("wd_release", 4'b0000);
        check("wd_err_sticky", {31'd0, mem_err}, 1);
        idle_inputs();
        step("wd_idle", 4'b0000);
        check("wd_err_sticky2", {31'd0, mem_err}, 1);

        // asynchronous reset in the middle of a wait
        mem_req = 1'b1; sram_ready = 1'b0;
        step("pre_rst_c1", 4'b1001);
        step("pre_rst_c2", 4'b1001);
        #2 reset = 1'b1;
        #1;
        check_ctrl("async_rst", 4'b0000);
        check("async_rst_stall", {16'd0, stall_cnt}, 0);
        check("async_rst_err", {31'd0, mem_err}, 0);
        check("async_rst_state", {31'd0, dut.state}, {31'd0, RUN});
        exp_stall = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        idle_inputs();
        step("post_rst_idle", 4'b0000);
        check("post_rst_wait", {24'd0, dut.wait_cnt}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

endmodule
